alu_controller: RTL and testbench
=================================

# alu_controller

Multi-cycle control sequencer that sits on the opposite side of the 16-bit ALU's control interface. It fetches 16-bit instructions and decodes them into the ALU select code, operand-B source and register-file addresses. It consumes the ALU's `take_branch` and `ovf` outputs, updates the program counter, and sequences register write-back and data-memory handshakes. It holds the program counter and the instruction register. All data values stay in the datapath.

## Interface
Parameters:
- PC_W, 8, program-counter width; the PC wraps modulo 2^PC_W.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- instr  in  16  instruction word at `pc`.
- instr_valid  in  1  `instr` is valid this cycle; sampled only in FETCH.
- imem_req  out  1  instruction fetch request.
- pc  out  PC_W  current program counter.
- alu_s  out  4  ALU operation select.
- alu_b_sel  out  1  0 = register B port; 1 = zero-extended IR[3:0].
- take_branch  in  1  from the ALU; sampled in EXEC.
- ovf  in  1  from the ALU; sampled in EXEC.
- res_en  out  1  datapath latches the ALU result `f`; 1-cycle pulse.
- rf_ra, rf_rb, rf_wa  out  4 each  register-file read A, read B and write addresses.
- rf_we  out  1  register-file write enable; 1-cycle pulse.
- wb_sel  out  1  write-back source: 0 = ALU result register, 1 = dmem read data.
- dmem_req  out  1  data-memory request.
- dmem_we  out  1  1 = store.
- dmem_ready  in  1  data-memory transfer complete.
- ovf_flag  out  1  sticky overflow flag.
- halted  out  1  controller is in HALT.

## Operation
Instruction fields:
- IR[15:12] op, IR[11:8] rd, IR[7:4] rs, IR[3:0] rt/imm4.
- Branches use IR[7:0] as a signed 8-bit offset.

Opcodes:
- 0–5, 8 (ADD, NOT, AND, OR, SRA, SLL, XOR), R-type:
  - alu_s = op[3:0] (8 maps to the ALU default, XOR).
  - rf_ra = rs, rf_rb = rt, rf_wa = rd, alu_b_sel = 0.
- 6 BEQZ / 7 BNEZ:
  - rf_ra = rd, alu_s = op.
  - If taken, pc ← pc + 1 + sext(IR[7:0]); otherwise pc ← pc + 1.
- 9 ADDI: alu_s = 0, alu_b_sel = 1, rf_ra = rs, rf_wa = rd.
- A LW:
  - Address = rs + imm4, computed with alu_s = 0 and alu_b_sel = 1.
  - Write-back uses wb_sel = 1, rf_wa = rd.
- B SW:
  - Address = rs + imm4, computed as for LW.
  - rf_rb = rd supplies the store data.
- F HALT.
- C, D, E are NOPs: pc ← pc + 1, with no writes.

States:
- FETCH:
  - imem_req = 1.
  - If instr_valid, IR ← instr → DECODE; otherwise remain in FETCH.
- DECODE:
  - NOP → FETCH with pc + 1.
  - HALT → HALT.
  - All other opcodes → EXEC.
- EXEC:
  - res_en = 1.
  - Branch → FETCH with pc updated.
  - LW/SW → MEM.
  - All other opcodes → WB.
  - ovf_flag ← ovf_flag | ovf, only for ADD (op 0) and ADDI (op 9).
- MEM:
  - dmem_req = 1; dmem_we = 1 for SW.
  - Remain in MEM until dmem_ready = 1.
  - On dmem_ready: LW → WB; SW → FETCH with pc + 1.
- WB: rf_we = 1 → FETCH with pc + 1.
- HALT:
  - halted = 1, imem_req = 0.
  - Only reset exits this state.

Output rules:
- The decode outputs (alu_s, alu_b_sel, rf_*, wb_sel) are driven from IR. They are stable from DECODE through WB. In FETCH and HALT they are 0.
- pc changes only on the edge leaving DECODE (NOP only), EXEC (branch only), MEM (SW only) or WB.
- PC arithmetic is modulo 2^PC_W:
  - pc + 1 wraps 0xFF → 0x00.
  - Branch targets wrap in both directions.

## Timing
Reset:
- reset = 1 at an edge forces: state = FETCH, pc = 0, IR = 0, ovf_flag = 0.
- All outputs are 0 while reset is high, including imem_req.
- Reset has priority in any state:
  - In MEM, dmem_req drops at that edge.
  - In WB, no write occurs at that edge.

Latency, with zero-wait memories and counted from the FETCH cycle in which instr_valid = 1:

| Instruction | Cycles | State sequence |
|---|---|---|
| R-type / ADDI | 4 | F, D, E, W |
| Branch | 3 | F, D, E |
| NOP | 2 | F, D |
| SW | 4 | F, D, E, M |
| LW | 5 | F, D, E, M, W |

Each cycle with instr_valid = 0 in FETCH, or dmem_ready = 0 in MEM, adds one cycle.

Signal rules:
- instr_valid is ignored outside FETCH.
- dmem_ready is ignored outside MEM.
- res_en and rf_we are high for exactly one cycle per instruction.
- take_branch and ovf are sampled on the edge ending EXEC.

## Test plan
- Reset, then ADD r1 = r2 + r3 (0x0123) with instr_valid = 1:
  - Required sequence: FETCH, DECODE, EXEC, WB.
  - alu_s = 0 and alu_b_sel = 0 during D/E/W.
  - rf_we pulses in the 4th cycle with rf_wa = 1.
  - pc goes 0 → 1.
- BNEZ r2, -3 (0x72FD) at pc = 0x05:
  - take_branch = 1 → pc = 0x03.
  - take_branch = 0 → pc = 0x06.
  - No rf_we in either case.
- LW r4, 2(r1) (0xA412) with dmem_ready held low for 3 cycles:
  - dmem_req = 1 for 4 cycles, dmem_we = 0.
  - Then WB with wb_sel = 1, rf_wa = 4.
  - Total latency is 8 cycles.
- ADD with ovf = 1 in EXEC:
  - ovf_flag = 1 and stays set through the following NOT and AND.
  - It clears only on reset.
- Wrap and stall cases:
  - At pc = 0xFF, a NOP (0xC000) → pc = 0x00.
  - Holding instr_valid = 0 for 5 cycles keeps the controller in FETCH with pc unchanged.
- Reset and halt:
  - Reset asserted during MEM of an SW → the next cycle has dmem_req = 0 and pc = 0.
  - HALT (0xF000) → halted = 1 and imem_req = 0 indefinitely, until reset.

Source files
------------

// File: rtl/alu_controller.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit ALU datapath.
// Holds PC and IR; drives ALU select, register-file addresses and memory handshakes.
module alu_controller #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     instr,
  input  logic            instr_valid,
  output logic            imem_req,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      alu_s,
  output logic            alu_b_sel,
  input  logic            take_branch,
  input  logic            ovf,
  output logic            res_en,
  output logic [3:0]      rf_ra,
  output logic [3:0]      rf_rb,
  output logic [3:0]      rf_wa,
  output logic            rf_we,
  output logic            wb_sel,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ready,
  output logic            ovf_flag,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            ovf_flag_q, ovf_flag_d;

  logic [3:0] op, rd, rs, rt;
  logic       is_rtype, is_branch, is_addi, is_lw, is_sw, is_nop, is_halt;
  logic       dec_active;
  logic [PC_W-1:0] pc_inc, pc_br;
  logic [31:0]     br_sum;

  logic       imem_req_c, res_en_c, rf_we_c, dmem_req_c, dmem_we_c, halted_c;
  logic [3:0] alu_s_c, rf_ra_c, rf_rb_c, rf_wa_c;
  logic       alu_b_sel_c, wb_sel_c;

  always_comb begin
    op = ir_q[15:12];
    rd = ir_q[11:8];
    rs = ir_q[7:4];
    rt = ir_q[3:0];
    is_rtype  = (op <= 4'd5) || (op == 4'd8);
    is_branch = (op == 4'd6) || (op == 4'd7);
    is_addi   = (op == 4'd9);
    is_lw     = (op == 4'hA);
    is_sw     = (op == 4'hB);
    is_nop    = (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
    is_halt   = (op == 4'hF);
  end

  // Branch target computed wide then truncated, so it wraps in both directions.
  always_comb begin
    pc_inc = pc_q + PC_W'(1);
    br_sum = 32'(pc_q) + 32'd1 + {{24{ir_q[7]}}, ir_q[7:0]};
    pc_br  = br_sum[PC_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ovf_flag_d = ovf_flag_q;
    imem_req_c = 1'b0;
    res_en_c   = 1'b0;
    rf_we_c    = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    halted_c   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_nop) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_en_c = 1'b1;
        if ((op == 4'd0) || is_addi) ovf_flag_d = ovf_flag_q | ovf;
        if (is_branch) begin
          pc_d    = take_branch ? pc_br : pc_inc;
          state_d = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_sw;
        if (dmem_ready) begin
          if (is_lw) begin
            state_d = S_WB;
          end else begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        rf_we_c = 1'b1;
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_HALT: halted_c = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    dec_active  = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                  (state_q == S_MEM) || (state_q == S_WB);
    alu_s_c     = '0;
    alu_b_sel_c = 1'b0;
    rf_ra_c     = '0;
    rf_rb_c     = '0;
    rf_wa_c     = '0;
    wb_sel_c    = 1'b0;
    if (dec_active) begin
      if (is_rtype) begin
        alu_s_c = op;
        rf_ra_c = rs;
        rf_rb_c = rt;
        rf_wa_c = rd;
      end else if (is_branch) begin
        alu_s_c = op;
        rf_ra_c = rd;
      end else if (is_addi || is_lw || is_sw) begin
        alu_b_sel_c = 1'b1;
        rf_ra_c     = rs;
        rf_rb_c     = is_sw ? rd : 4'd0;
        rf_wa_c     = is_sw ? 4'd0 : rd;
        wb_sel_c    = is_lw;
      end
    end
  end

  // Every output is held low combinationally while reset is asserted.
  always_comb begin
    imem_req  = imem_req_c & ~reset;
    pc        = reset ? '0 : pc_q;
    alu_s     = reset ? '0 : alu_s_c;
    alu_b_sel = alu_b_sel_c & ~reset;
    res_en    = res_en_c & ~reset;
    rf_ra     = reset ? '0 : rf_ra_c;
    rf_rb     = reset ? '0 : rf_rb_c;
    rf_wa     = reset ? '0 : rf_wa_c;
    rf_we     = rf_we_c & ~reset;
    wb_sel    = wb_sel_c & ~reset;
    dmem_req  = dmem_req_c & ~reset;
    dmem_we   = dmem_we_c & ~reset;
    ovf_flag  = ovf_flag_q & ~reset;
    halted    = halted_c & ~reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= '0;
      ir_q       <= '0;
      ovf_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ovf_flag_q <= ovf_flag_d;
    end
  end

endmodule

// File: tb/tb_alu_controller.sv
// Instruction-level reference model for alu_controller: each instruction expands
// into its expected per-cycle output trace, compared against the DUT every cycle.
module tb_alu_controller;

  typedef struct packed {
    logic       imem_req;
    logic [7:0] pc;
    logic [3:0] alu_s;
    logic       alu_b_sel;
    logic       res_en;
    logic [3:0] rf_ra;
    logic [3:0] rf_rb;
    logic [3:0] rf_wa;
    logic       rf_we;
    logic       wb_sel;
    logic       dmem_req;
    logic       dmem_we;
    logic       ovf_flag;
    logic       halted;
  } outs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        take_branch = 1'b0;
  logic        ovf = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, alu_b_sel, res_en, rf_we, wb_sel, dmem_req, dmem_we, ovf_flag, halted;
  logic [7:0]  pc;
  logic [3:0]  alu_s, rf_ra, rf_rb, rf_wa;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_no = 0;
  outs_t exp_q[$];
  logic [7:0] m_pc;
  logic       m_ovf;

  alu_controller #(.PC_W(8)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .imem_req(imem_req), .pc(pc), .alu_s(alu_s), .alu_b_sel(alu_b_sel),
    .take_branch(take_branch), .ovf(ovf), .res_en(res_en),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_wa(rf_wa), .rf_we(rf_we), .wb_sel(wb_sel),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .ovf_flag(ovf_flag), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    outs_t e, a;
    cyc_no++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.imem_req = imem_req;  a.pc = pc;          a.alu_s = alu_s;
      a.alu_b_sel = alu_b_sel; a.res_en = res_en;  a.rf_ra = rf_ra;
      a.rf_rb = rf_rb;        a.rf_wa = rf_wa;    a.rf_we = rf_we;
      a.wb_sel = wb_sel;      a.dmem_req = dmem_req; a.dmem_we = dmem_we;
      a.ovf_flag = ovf_flag;  a.halted = halted;
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL outputs cycle %0d: got %h required %h", cyc_no, a, e);
      end
    end
  end

  function automatic void chk(string nm, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endfunction

  function automatic outs_t base();
    outs_t e = '0;
    e.pc = m_pc;
    e.ovf_flag = m_ovf;
    return e;
  endfunction

  // Decode table: what each opcode must present on the control outputs.
  function automatic outs_t dec(input logic [15:0] ins);
    outs_t e = base();
    logic [3:0] op = ins[15:12];
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8: begin
        e.alu_s = op; e.rf_ra = ins[7:4]; e.rf_rb = ins[3:0]; e.rf_wa = ins[11:8];
      end
      4'h6, 4'h7: begin e.alu_s = op; e.rf_ra = ins[11:8]; end
      4'h9: begin e.alu_b_sel = 1'b1; e.rf_ra = ins[7:4]; e.rf_wa = ins[11:8]; end
      4'hA: begin
        e.alu_b_sel = 1'b1; e.rf_ra = ins[7:4]; e.rf_wa = ins[11:8]; e.wb_sel = 1'b1;
      end
      4'hB: begin e.alu_b_sel = 1'b1; e.rf_ra = ins[7:4]; e.rf_rb = ins[11:8]; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic cyc(input outs_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_other();
    take_branch = 1'($urandom);
    ovf = 1'($urandom);
    dmem_ready = 1'($urandom);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      rnd_other();
      instr_valid = 1'($urandom);
      cyc('0);
    end
    reset = 1'b0;
    m_pc = '0;
    m_ovf = 1'b0;
  endtask

  task automatic do_instr(input logic [15:0] ins, input int fst, input int mst,
                          input bit tb, input bit ov, input bit rst_in_mem,
                          output int ncyc);
    outs_t e, d;
    logic [3:0] op = ins[15:12];
    ncyc = 0;
    repeat (fst) begin
      instr = 16'($urandom); instr_valid = 1'b0; rnd_other();
      e = base(); e.imem_req = 1'b1; cyc(e);
    end
    instr = ins; instr_valid = 1'b1; rnd_other();
    e = base(); e.imem_req = 1'b1; cyc(e); ncyc++;
    instr = 16'($urandom); instr_valid = 1'($urandom); rnd_other();
    d = dec(ins); cyc(d); ncyc++;
    if (op >= 4'hC && op <= 4'hE) begin m_pc = m_pc + 8'd1; return; end
    if (op == 4'hF) return;
    take_branch = tb; ovf = ov; dmem_ready = 1'($urandom); instr_valid = 1'($urandom);
    e = d; e.res_en = 1'b1; cyc(e); ncyc++;
    if (op == 4'h0 || op == 4'h9) m_ovf = m_ovf | ov;
    d.ovf_flag = m_ovf;
    if (op == 4'h6 || op == 4'h7) begin
      m_pc = tb ? (m_pc + 8'd1 + ins[7:0]) : (m_pc + 8'd1);
      return;
    end
    if (op == 4'hA || op == 4'hB) begin
      e = d; e.dmem_req = 1'b1; e.dmem_we = (op == 4'hB);
      repeat (mst) begin
        dmem_ready = 1'b0; take_branch = 1'($urandom); ovf = 1'($urandom);
        cyc(e); ncyc++;
      end
      if (rst_in_mem) begin do_reset(1); return; end
      dmem_ready = 1'b1; cyc(e); ncyc++;
      if (op == 4'hB) begin m_pc = m_pc + 8'd1; return; end
    end
    rnd_other(); instr_valid = 1'($urandom);
    e = d; e.rf_we = 1'b1; cyc(e); ncyc++;
    m_pc = m_pc + 8'd1;
  endtask

  initial begin
    int n;
    logic [3:0] op;
    m_pc = '0;
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);

    do_instr(16'h0123, 0, 0, 1'b0, 1'b0, 1'b0, n);
    chk("add_latency", n, 4);
    chk("add_pc", int'(pc), 1);
    repeat (4) do_instr(16'hC000, 0, 0, 1'b0, 1'b0, 1'b0, n);
    chk("nop_latency", n, 2);
    chk("pc_at_5", int'(pc), 5);
    do_instr(16'h72FD, 0, 0, 1'b1, 1'b0, 1'b0, n);
    chk("branch_latency", n, 3);
    chk("bnez_taken_pc", int'(pc), 3);
    repeat (2) do_instr(16'hD000, 0, 0, 1'b0, 1'b0, 1'b0, n);
    do_instr(16'h72FD, 0, 0, 1'b0, 1'b0, 1'b0, n);
    chk("bnez_not_taken_pc", int'(pc), 6);
    do_instr(16'hA412, 0, 3, 1'b0, 1'b0, 1'b0, n);
    chk("lw_stall_latency", n, 8);
    do_instr(16'hB312, 0, 0, 1'b0, 1'b0, 1'b0, n);
    chk("sw_latency", n, 4);

    do_instr(16'h1100, 0, 0, 1'b0, 1'b1, 1'b0, n);
    chk("not_ovf_ignored", int'(ovf_flag), 0);
    do_instr(16'h0123, 0, 0, 1'b0, 1'b1, 1'b0, n);
    chk("add_ovf_set", int'(ovf_flag), 1);
    do_instr(16'h1200, 0, 0, 1'b0, 1'b0, 1'b0, n);
    do_instr(16'h2345, 0, 0, 1'b0, 1'b0, 1'b0, n);
    chk("ovf_sticky", int'(ovf_flag), 1);
    do_instr(16'hC000, 5, 0, 1'b0, 1'b0, 1'b0, n);

    do_reset(1);
    chk("ovf_cleared", int'(ovf_flag), 0);
    do_instr(16'h70FE, 0, 0, 1'b1, 1'b0, 1'b0, n);
    chk("branch_wrap_back", int'(pc), 255);
    do_instr(16'hC000, 0, 0, 1'b0, 1'b0, 1'b0, n);
    chk("nop_wrap", int'(pc), 0);
    do_instr(16'h0000, 0, 0, 1'b0, 1'b0, 1'b0, n);
    do_instr(16'hB312, 0, 2, 1'b0, 1'b0, 1'b1, n);
    chk("rst_mem_dmem_req", int'(dmem_req), 0);
    chk("rst_mem_pc", int'(pc), 0);

    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 14));
      if ($urandom_range(0, 39) == 0) do_reset(1);
      do_instr({op, 12'($urandom)}, $urandom_range(0, 2), $urandom_range(0, 3),
               1'($urandom), 1'($urandom), 1'b0, n);
    end

    do_instr(16'hF000, 1, 0, 1'b0, 1'b0, 1'b0, n);
    repeat (12) begin
      outs_t e;
      instr = 16'($urandom); instr_valid = 1'($urandom); rnd_other();
      e = base(); e.halted = 1'b1; cyc(e);
    end
    chk("halted", int'(halted), 1);
    chk("halt_no_fetch", int'(imem_req), 0);
    do_reset(1);
    do_instr(16'h9456, 0, 0, 1'b0, 1'b1, 1'b0, n);
    chk("after_halt_addi_pc", int'(pc), 1);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
